// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared store-buffer defaults and entry type
package riscv_pipe_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-entry word match of a load address over the buffer
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0]              ld_adr,
  input  logic [DEPTH-1:0][AW-1:0]   adr,
  input  logic [DEPTH-1:0][DW-1:0]   data,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  output logic                       hit,
  output logic [DW-1:0]              hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] slot;
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if ((PW+1)'(k) < count && ((adr[slot] ^ ld_adr) >> 2) == '0) begin
        hit = 1'b1;
        hit_data = data[slot];
      end
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO to dmem with same-word load forwarding
module store_write_buffer
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [AW-1:0]            DataAdr,
  input  logic [DW-1:0]            WriteData,
  input  logic [AW-1:0]            LdAdr,
  output logic                     LdHit,
  output logic [DW-1:0]            LdData,
  output logic                     Stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_adr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0][AW-1:0] adr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0] wr_q, rd_q;
  logic push, pop, full;
  assign full = Count == (PW+1)'(DEPTH);
  assign mem_we = Count != '0;
  assign Empty = ~mem_we;
  assign pop = mem_we & mem_ready;
  // a full buffer still accepts a store when the head drains the same cycle
  assign push = MemWrite & (~full | pop);
  assign Stall = MemWrite & ~push;
  assign mem_adr = adr_q[rd_q];
  assign mem_wdata = data_q[rd_q];
  always_ff @(posedge clk) begin
    if (reset) begin
      Count <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      Count <= Count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_q] <= DataAdr;
      data_q[wr_q] <= WriteData;
    end
  end
  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
    .ld_adr(LdAdr),
    .adr(adr_q),
    .data(data_q),
    .head(rd_q),
    .count(Count),
    .hit(LdHit),
    .hit_data(LdData)
  );
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: table vectors, hand sequences and a scoreboarded random run
module tb_store_write_buffer;
  import riscv_pipe_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, mem_ready = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0, LdAdr = '0;
  logic LdHit, Stall, mem_we, Empty;
  logic [31:0] LdData, mem_adr, mem_wdata;
  logic [2:0] Count;
  int vectors = 0, miscompares = 0, maxc = 0;
  bit last_stall = 0;
  sb_entry_t q[$];

  always #5 clk = ~clk;

  store_write_buffer dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .LdAdr(LdAdr), .LdHit(LdHit), .LdData(LdData),
    .Stall(Stall), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .Empty(Empty), .Count(Count)
  );

  typedef struct {
    logic mw; logic [31:0] adr, wd; logic rdy; logic [31:0] ld;
    logic stall; int cnt; logic we; logic [31:0] madr; logic hit; logic [31:0] ldd;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // scoreboard step: check outputs against the model, then apply the edge
  task automatic adv();
    logic acc, pop, hit;
    logic [31:0] d;
    int n;
    n = q.size();
    if (reset) begin
      q.delete();
      last_stall = 0;
    end else begin
      pop = n != 0 && mem_ready;
      acc = MemWrite && (n < DEPTH || pop);
      hit = 0;
      d = 0;
      foreach (q[i]) if (q[i].adr[31:2] == LdAdr[31:2]) begin hit = 1; d = q[i].data; end
      chk("stall", Stall, MemWrite && !acc);
      chk("mem_we", mem_we, n != 0);
      chk("count", Count, n);
      chk("empty", Empty, n == 0);
      chk("ld_hit", LdHit, hit);
      chk("ld_data", LdData, d);
      if (n != 0) begin
        chk("mem_adr", mem_adr, q[0].adr);
        chk("mem_wdata", mem_wdata, q[0].data);
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{DataAdr, WriteData});
      last_stall = MemWrite && !acc;
    end
    if (q.size() > maxc) maxc = q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    adv();
  endtask

  initial begin
    tbl = '{
      '{1, 32'h0,  32'hA0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0},
      '{1, 32'h4,  32'hA4, 0, 32'h0,  0, 1, 1, 32'h0,  1, 32'hA0},
      '{1, 32'h8,  32'hA8, 0, 32'h4,  0, 2, 1, 32'h0,  1, 32'hA4},
      '{1, 32'hC,  32'hAC, 0, 32'h8,  0, 3, 1, 32'h0,  1, 32'hA8},
      '{1, 32'h10, 32'hB0, 0, 32'hC,  1, 4, 1, 32'h0,  1, 32'hAC},
      '{1, 32'h10, 32'hB0, 0, 32'h10, 1, 4, 1, 32'h0,  0, 32'h0},
      '{1, 32'h10, 32'hB0, 1, 32'h0,  0, 4, 1, 32'h0,  1, 32'hA0},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 4, 1, 32'h4,  0, 32'h0},
      '{0, 32'h0,  32'h0,  1, 32'hC,  0, 3, 1, 32'h8,  1, 32'hAC},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 2, 1, 32'hC,  0, 32'h0},
      '{0, 32'h0,  32'h0,  1, 32'h12, 0, 1, 1, 32'h10, 1, 32'hB0},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0},
      '{1, 32'h64, 32'h11, 0, 32'h66, 0, 0, 0, 32'h0,  0, 32'h0},
      '{1, 32'h64, 32'h22, 0, 32'h66, 0, 1, 1, 32'h64, 1, 32'h11},
      '{0, 32'h0,  32'h0,  0, 32'h66, 0, 2, 1, 32'h64, 1, 32'h22},
      '{0, 32'h0,  32'h0,  0, 32'h68, 0, 2, 1, 32'h64, 0, 32'h0},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 2, 1, 32'h64, 0, 32'h0},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 1, 1, 32'h64, 0, 32'h0},
      '{0, 32'h0,  32'h0,  1, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0}
    };
    #1;
    repeat (3) tick();
    reset = 0;
    to_neg();
    chk("idle_empty", Empty, 1);
    chk("idle_count", Count, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_stall", Stall, 0);
    adv();
    MemWrite = 1; DataAdr = 32'h132; WriteData = 32'hABCDE02E;
    tick();
    MemWrite = 0;
    to_neg();
    chk("st_we", mem_we, 1);
    chk("st_adr", mem_adr, 32'h132);
    chk("st_data", mem_wdata, 32'hABCDE02E);
    mem_ready = 1;
    adv();
    to_neg();
    chk("st_empty", Empty, 1);
    adv();
    foreach (tbl[i]) begin
      MemWrite = tbl[i].mw; DataAdr = tbl[i].adr; WriteData = tbl[i].wd;
      mem_ready = tbl[i].rdy; LdAdr = tbl[i].ld;
      to_neg();
      chk($sformatf("t%0d_stall", i), Stall, tbl[i].stall);
      chk($sformatf("t%0d_count", i), Count, tbl[i].cnt);
      chk($sformatf("t%0d_we", i), mem_we, tbl[i].we);
      if (tbl[i].we) chk($sformatf("t%0d_madr", i), mem_adr, tbl[i].madr);
      chk($sformatf("t%0d_hit", i), LdHit, tbl[i].hit);
      chk($sformatf("t%0d_ldd", i), LdData, tbl[i].ldd);
      adv();
    end
    mem_ready = 0; MemWrite = 1;
    for (int i = 0; i < 3; i++) begin
      DataAdr = 32'h200 + 32'(4 * i); WriteData = 32'hC0 + 32'(i);
      tick();
    end
    MemWrite = 0; mem_ready = 1; reset = 1;
    tick();
    reset = 0;
    to_neg();
    chk("rst_count", Count, 0);
    chk("rst_we", mem_we, 0);
    adv();
    repeat (3) begin
      to_neg();
      chk("rst_idle_we", mem_we, 0);
      adv();
    end
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall) begin
        MemWrite = 1'($urandom_range(0, 1));
        DataAdr = 32'($urandom_range(0, 31));
        WriteData = $urandom;
      end
      mem_ready = $urandom_range(0, 3) < ((i % 400) < 200 ? 1 : 3);
      LdAdr = 32'($urandom_range(0, 31));
      tick();
    end
    MemWrite = 0; mem_ready = 1;
    repeat (6) tick();
    chk("drained", q.size(), 0);
    chk("max_count", maxc <= DEPTH, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
